pkt_store_fwd: RTL

Parametrised store-and-forward packet buffer for the receive path, placed after the CRC checker and before the forwarding/copy logic.
- Writes each incoming packet into a circular data RAM using a speculative write pointer.
- On the final beat, commits the packet when the CRC is good and it fits; otherwise rolls the write pointer back and counts a drop.
- Committed lengths are queued in a length FIFO. The read side streams whole packets out on request.

---
 rtl/pkt_store_pkg.sv | 18 +
 rtl/pkt_len_fifo.sv | 44 ++++
 rtl/pkt_store_fwd.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/pkt_store_pkg.sv
// Shared types and helpers for the store-and-forward packet buffer.
package pkt_store_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_READ = 1'b1
  } state_e;

  // Occupancy between two wrap-bit pointers of width w (w <= 31).
  function automatic logic [31:0] ptr_occ(input logic [31:0] head,
                                          input logic [31:0] tail,
                                          input int          w);
    logic [31:0] mask;
    mask = (32'd1 << w) - 32'd1;
    return (head - tail) & mask;
  endfunction

endpackage

// File: rtl/pkt_len_fifo.sv
// Synchronous show-ahead FIFO holding committed packet lengths.
module pkt_len_fifo #(
  parameter int W  = 13,
  parameter int AW = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic         empty_o,
  output logic         full_o,
  output logic [W-1:0] head_o
);

  localparam int DEPTH = 1 << AW;

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wp_q;
  logic [AW:0]  rp_q;
  logic         push_s;
  logic         pop_s;

  assign empty_o = (wp_q == rp_q);
  assign full_o  = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign head_o  = empty_o ? '0 : mem_q[rp_q[AW-1:0]];
  assign push_s  = push_i && !full_o;
  assign pop_s   = pop_i && !empty_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      if (push_s) wp_q <= wp_q + (AW+1)'(1);
      if (pop_s)  rp_q <= rp_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_s) mem_q[wp_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/pkt_store_fwd.sv
// Store-and-forward packet buffer: speculative writes into a circular RAM,
// commit or roll back on the last beat, whole-packet streaming on request.
module pkt_store_fwd
  import pkt_store_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 12,
  parameter int PKT_AW  = 2,
  parameter int MIN_LEN = 1,
  parameter int CNT_W   = 16
) (
  input  logic              iclk,
  input  logic              i_rst_n,
  input  logic              i_wr_valid,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_wr_last,
  input  logic              i_wr_crc_ok,
  input  logic              i_rd_start,
  output logic              o_rd_valid,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_last,
  output logic              o_pkt_avail,
  output logic [ADDR_W:0]   o_pkt_len,
  output logic [ADDR_W:0]   o_free,
  output logic [CNT_W-1:0]  o_drop_cnt,
  output logic              o_busy
);

  localparam int PW  = ADDR_W + 1;
  localparam int CAP = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [CAP];
  logic [PW-1:0]     wr_spec_q, wr_cmt_q, rd_ptr_q, len_q, rem_q;
  logic              ovf_q;
  logic [CNT_W-1:0]  drop_q;
  state_e            state_q;
  logic              rd_valid_q, rd_last_q;
  logic [DATA_W-1:0] rd_data_q;

  logic [PW-1:0] occ_spec_s, occ_cmt_s, len_inc_s, fifo_head_s;
  logic          space_ok_s, beat_wr_s, ovf_inc_s, commit_s, drop_s;
  logic          fifo_empty_s, fifo_full_s, fifo_pop_s;

  assign occ_spec_s = PW'(ptr_occ(32'(wr_spec_q), 32'(rd_ptr_q), PW));
  assign occ_cmt_s  = PW'(ptr_occ(32'(wr_cmt_q), 32'(rd_ptr_q), PW));
  assign fifo_pop_s = (state_q == ST_IDLE) && i_rd_start && !fifo_empty_s;

  // Space check on the pre-update read pointer, then last-beat verdict.
  always_comb begin
    space_ok_s = (occ_spec_s < PW'(CAP));
    beat_wr_s  = i_wr_valid && space_ok_s;
    len_inc_s  = (beat_wr_s && (len_q != '1)) ? len_q + PW'(1) : len_q;
    ovf_inc_s  = ovf_q | (i_wr_valid & ~space_ok_s);
    commit_s   = 1'b0;
    drop_s     = 1'b0;
    if (i_wr_valid && i_wr_last) begin
      if (i_wr_crc_ok && !ovf_inc_s && (len_inc_s >= PW'(MIN_LEN)) && !fifo_full_s) begin
        commit_s = 1'b1;
      end else begin
        drop_s = 1'b1;
      end
    end else begin
      commit_s = 1'b0;
      drop_s   = 1'b0;
    end
  end

  always_ff @(posedge iclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_spec_q <= '0;
      wr_cmt_q  <= '0;
      len_q     <= '0;
      ovf_q     <= 1'b0;
      drop_q    <= '0;
    end else begin
      if (beat_wr_s) wr_spec_q <= wr_spec_q + PW'(1);
      len_q <= len_inc_s;
      ovf_q <= ovf_inc_s;
      if (commit_s) begin
        wr_cmt_q <= wr_spec_q + PW'(1);
        len_q    <= '0;
        ovf_q    <= 1'b0;
      end else if (drop_s) begin
        wr_spec_q <= wr_cmt_q;
        len_q     <= '0;
        ovf_q     <= 1'b0;
        if (drop_q != '1) drop_q <= drop_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge iclk) begin
    if (beat_wr_s) mem_q[wr_spec_q[ADDR_W-1:0]] <= i_wr_data;
  end

  // Read FSM: one registered RAM read per cycle while in ST_READ.
  always_ff @(posedge iclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      rd_ptr_q   <= '0;
      rem_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (fifo_pop_s) begin
            rem_q   <= fifo_head_s;
            state_q <= ST_READ;
          end
        end
        ST_READ: begin
          rd_data_q  <= mem_q[rd_ptr_q[ADDR_W-1:0]];
          rd_valid_q <= 1'b1;
          rd_last_q  <= (rem_q == PW'(1));
          rd_ptr_q   <= rd_ptr_q + PW'(1);
          rem_q      <= rem_q - PW'(1);
          if (rem_q == PW'(1)) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  pkt_len_fifo #(
    .W  (PW),
    .AW (PKT_AW)
  ) u_len_fifo (
    .clk_i   (iclk),
    .rst_ni  (i_rst_n),
    .push_i  (commit_s),
    .din_i   (len_inc_s),
    .pop_i   (fifo_pop_s),
    .empty_o (fifo_empty_s),
    .full_o  (fifo_full_s),
    .head_o  (fifo_head_s)
  );

  assign o_rd_valid  = rd_valid_q;
  assign o_rd_data   = rd_data_q;
  assign o_rd_last   = rd_last_q;
  assign o_pkt_avail = !fifo_empty_s;
  assign o_pkt_len   = fifo_head_s;
  assign o_free      = PW'(CAP) - occ_cmt_s;
  assign o_drop_cnt  = drop_q;
  assign o_busy      = (state_q == ST_READ);

endmodule
